// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - single-outstanding instruction fetch controller with redirect/stall absorption
// Define FETCH_PERF_CNT_EN to add perf_fetched / perf_discarded counters.
module inst_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1fc00000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_pc,
  output logic              inst_sram_req,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_discarded,
`endif
  output logic              fetch_available
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, addr_q, redir_pc_q, buf_pc_q, inst_pc_q;
  logic [INST_W-1:0] buf_inst_q, inst_q;
  logic              req_q, fa_q, discard_q, redir_pend_q;

  logic              redir_d;
  logic [ADDR_W-1:0] redir_tgt_d, pc_inc_d;

  assign redir_d     = flush | branch_en;
  assign redir_tgt_d = flush ? flush_pc : branch_pc;
  assign pc_inc_d    = pc_q + ADDR_W'(4);

  // The one-entry buffer is full exactly while in HOLD, so no separate valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      fa_q         <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      buf_inst_q   <= '0;
      buf_pc_q     <= '0;
      redir_pc_q   <= '0;
      discard_q    <= 1'b0;
      redir_pend_q <= 1'b0;
    end else begin
      fa_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (redir_d) pc_q <= redir_tgt_d;
          addr_q  <= redir_d ? redir_tgt_d : pc_q;
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: begin
          if (redir_d) redir_pc_q <= redir_tgt_d;
          if (inst_sram_addr_ok) begin
            req_q     <= 1'b0;
            discard_q <= redir_d | redir_pend_q;
            state_q   <= WAIT;
          end else if (redir_d) begin
            redir_pend_q <= 1'b1;
          end
        end
        WAIT: begin
          if (inst_sram_data_ok) begin
            if (discard_q || redir_d) begin
              pc_q         <= redir_d ? redir_tgt_d : redir_pc_q;
              addr_q       <= redir_d ? redir_tgt_d : redir_pc_q;
              discard_q    <= 1'b0;
              redir_pend_q <= 1'b0;
              req_q        <= 1'b1;
              state_q      <= REQ;
            end else if (stall) begin
              buf_inst_q <= inst_sram_rdata;
              buf_pc_q   <= pc_q;
              pc_q       <= pc_inc_d;
              state_q    <= HOLD;
            end else begin
              inst_q    <= inst_sram_rdata;
              inst_pc_q <= pc_q;
              fa_q      <= 1'b1;
              pc_q      <= pc_inc_d;
              addr_q    <= pc_inc_d;
              req_q     <= 1'b1;
              state_q   <= REQ;
            end
          end else if (redir_d) begin
            discard_q  <= 1'b1;
            redir_pc_q <= redir_tgt_d;
          end
        end
        HOLD: begin
          if (redir_d) begin
            pc_q    <= redir_tgt_d;
            addr_q  <= redir_tgt_d;
            req_q   <= 1'b1;
            state_q <= REQ;
          end else if (!stall) begin
            inst_q    <= buf_inst_q;
            inst_pc_q <= buf_pc_q;
            fa_q      <= 1'b1;
            addr_q    <= pc_q;
            req_q     <= 1'b1;
            state_q   <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_sram_req   = req_q;
  assign inst_sram_addr  = addr_q;
  assign inst            = inst_q;
  assign inst_pc         = inst_pc_q;
  assign fetch_available = fa_q;

`ifdef FETCH_PERF_CNT_EN
  logic        fetch_evt, drop_evt;
  logic [31:0] perf_fetched_q, perf_discarded_q;

  assign fetch_evt = ((state_q == WAIT) && inst_sram_data_ok && !discard_q && !redir_d && !stall) ||
                     ((state_q == HOLD) && !redir_d && !stall);
  assign drop_evt  = ((state_q == WAIT) && inst_sram_data_ok && (discard_q || redir_d)) ||
                     ((state_q == HOLD) && redir_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      if (fetch_evt) perf_fetched_q   <= perf_fetched_q + 32'd1;
      if (drop_evt)  perf_discarded_q <= perf_discarded_q + 32'd1;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - self-checking bench for inst_fetch_ctrl: directed table, reset sequence, random vs model
module tb_inst_fetch_ctrl;

  localparam logic [31:0] R = 32'h1fc00000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_en, addr_ok, data_ok;
  logic [31:0] flush_pc, branch_pc, rdata;
  logic        req, fa;
  logic [31:0] addr, inst, inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_discarded;
`endif

  int passed = 0;
  int total  = 0;

  inst_fetch_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .branch_en         (branch_en),
    .branch_pc         (branch_pc),
    .inst_sram_req     (req),
    .inst_sram_addr    (addr),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata),
    .inst              (inst),
    .inst_pc           (inst_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched      (perf_fetched),
    .perf_discarded    (perf_discarded),
`endif
    .fetch_available   (fa)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aok, dok;
    logic [31:0] rd;
    logic        stl, fl;
    logic [31:0] fpc;
    logic        br;
    logic [31:0] bpc;
    logic        xreq;
    logic [31:0] xaddr;
    logic        xfa;
    logic [31:0] xinst, xpc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic aok, logic dok, logic [31:0] rd, logic stl, logic fl, logic [31:0] fpc,
                             logic br, logic [31:0] bpc, logic xreq, logic [31:0] xaddr, logic xfa,
                             logic [31:0] xinst, logic [31:0] xpc);
    vec_t r;
    r = '{aok, dok, rd, stl, fl, fpc, br, bpc, xreq, xaddr, xfa, xinst, xpc};
    return r;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9e3779b9;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_en = 0; addr_ok = 0; data_ok = 0;
    flush_pc = 0; branch_pc = 0; rdata = 0;
  endtask

  // random-phase model state
  logic [31:0] exp_next, cur_addr, buf_addr, exp_inst, exp_pc, last_inst, last_pc, mem_addr;
  logic        in_flight, stale, buf_has, exp_fa, mem_busy;
  int          n_fetch, n_drop;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // one row per cycle: inputs driven this cycle, outputs expected this cycle
    vq.push_back(v(0,0,0,           0,0,0,           0,0,           0,R,           0,0,           0));
    vq.push_back(v(1,0,0,           0,0,0,           0,0,           1,R,           0,0,           0));
    vq.push_back(v(0,1,32'h02800c21,0,0,0,           0,0,           0,0,           0,0,           0));
    vq.push_back(v(1,0,0,           0,0,0,           0,0,           1,R+4,         1,32'h02800c21,R));
    vq.push_back(v(0,1,32'h1c000004,1,0,0,           0,0,           0,0,           0,32'h02800c21,R));
    vq.push_back(v(0,0,0,           1,0,0,           0,0,           0,0,           0,32'h02800c21,R));
    vq.push_back(v(0,0,0,           1,0,0,           0,0,           0,0,           0,32'h02800c21,R));
    vq.push_back(v(0,0,0,           0,0,0,           0,0,           0,0,           0,32'h02800c21,R));
    vq.push_back(v(1,0,0,           0,0,0,           0,0,           1,R+8,         1,32'h1c000004,R+4));
    vq.push_back(v(0,0,0,           0,0,0,           1,32'h1c001000,0,0,           0,32'h1c000004,R+4));
    vq.push_back(v(0,1,32'hdeadbeef,0,0,0,           0,0,           0,0,           0,32'h1c000004,R+4));
    vq.push_back(v(1,0,0,           0,1,32'h1c008000,1,32'h1c001000,1,32'h1c001000,0,32'h1c000004,R+4));
    vq.push_back(v(0,1,32'h11111111,0,0,0,           0,0,           0,0,           0,32'h1c000004,R+4));
    vq.push_back(v(1,0,0,           0,0,0,           0,0,           1,32'h1c008000,0,32'h1c000004,R+4));
    vq.push_back(v(0,1,32'h22222222,0,0,0,           0,0,           0,0,           0,32'h1c000004,R+4));
    vq.push_back(v(0,0,0,           0,0,0,           1,32'hfffffffc,1,32'h1c008004,1,32'h22222222,32'h1c008000));
    vq.push_back(v(1,0,0,           0,0,0,           0,0,           1,32'h1c008004,0,32'h22222222,32'h1c008000));
    vq.push_back(v(0,1,32'h33333333,0,0,0,           0,0,           0,0,           0,32'h22222222,32'h1c008000));
    vq.push_back(v(1,0,0,           0,0,0,           0,0,           1,32'hfffffffc,0,32'h22222222,32'h1c008000));
    vq.push_back(v(0,1,32'h44444444,0,0,0,           0,0,           0,0,           0,32'h22222222,32'h1c008000));
    vq.push_back(v(1,0,0,           0,0,0,           0,0,           1,32'h00000000,1,32'h44444444,32'hfffffffc));
    vq.push_back(v(0,1,32'h55555555,1,0,0,           0,0,           0,0,           0,32'h44444444,32'hfffffffc));
    vq.push_back(v(0,0,0,           1,1,32'h1c000100,0,0,           0,0,           0,32'h44444444,32'hfffffffc));
    vq.push_back(v(0,0,0,           0,0,0,           0,0,           1,32'h1c000100,0,32'h44444444,32'hfffffffc));

    for (int i = 0; i < vq.size(); i++) begin
      addr_ok = vq[i].aok; data_ok = vq[i].dok; rdata = vq[i].rd; stall = vq[i].stl;
      flush = vq[i].fl; flush_pc = vq[i].fpc; branch_en = vq[i].br; branch_pc = vq[i].bpc;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), {31'd0, req}, {31'd0, vq[i].xreq});
      if (vq[i].xreq) chk($sformatf("vec%0d_addr", i), addr, vq[i].xaddr);
      chk($sformatf("vec%0d_fa", i), {31'd0, fa}, {31'd0, vq[i].xfa});
      chk($sformatf("vec%0d_inst", i), inst, vq[i].xinst);
      chk($sformatf("vec%0d_pc", i), inst_pc, vq[i].xpc);
`ifdef FETCH_PERF_CNT_EN
      if (i == vq.size() - 1) begin
        chk("vec_perf_fetched", perf_fetched, 32'd4);
        chk("vec_perf_discarded", perf_discarded, 32'd4);
      end
`endif
      @(posedge clk); #1;
    end

    // reset while a request is outstanding, with data_ok during and after reset
    idle_inputs();
    addr_ok = 1;
    @(negedge clk);
    @(posedge clk); #1;
    addr_ok = 0; reset = 1; data_ok = 1; rdata = 32'hcafef00d;
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, R);
    chk("rst_fa", {31'd0, fa}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_late_fa", {31'd0, fa}, 32'd0);
    @(posedge clk); #1;
    data_ok = 0;
    @(negedge clk);
    chk("rst_first_req", {31'd0, req}, 32'd1);
    chk("rst_first_addr", addr, R);
    chk("rst_late_fa2", {31'd0, fa}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_discarded", perf_discarded, 32'd0);
`endif

    // randomized traffic against a transaction-level model
    @(posedge clk); #1;
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_next = R; in_flight = 0; stale = 0; buf_has = 0; exp_fa = 0;
    last_inst = 0; last_pc = 0; mem_busy = 0; cur_addr = 0; buf_addr = 0; mem_addr = 0;
    exp_inst = 0; exp_pc = 0; n_fetch = 0; n_drop = 0;
    for (int c = 0; c < 4000; c++) begin
      addr_ok   = req && !mem_busy && ($urandom_range(0, 3) != 0);
      data_ok   = mem_busy && ($urandom_range(0, 2) != 0);
      rdata     = data_ok ? mem_word(mem_addr) : $urandom;
      stall     = ($urandom_range(0, 9) < 3);
      flush     = ($urandom_range(0, 19) == 0);
      flush_pc  = $urandom & 32'hfffffffc;
      branch_en = ($urandom_range(0, 14) == 0);
      branch_pc = $urandom & 32'hfffffffc;
      @(negedge clk);
      chk("rnd_fa", {31'd0, fa}, {31'd0, exp_fa});
      if (exp_fa) begin
        last_inst = exp_inst;
        last_pc   = exp_pc;
      end
      chk("rnd_inst", inst, last_inst);
      chk("rnd_pc", inst_pc, last_pc);
      if (buf_has) chk("rnd_no_req_in_hold", {31'd0, req}, 32'd0);
      if (req) begin
        if (!in_flight) begin
          chk("rnd_req_addr", addr, exp_next);
          in_flight = 1; cur_addr = addr; stale = 0;
        end else begin
          chk("rnd_addr_stable", addr, cur_addr);
        end
      end
      exp_fa = 0;
      if (flush || branch_en) begin
        if (in_flight) stale = 1;
        if (buf_has) n_drop++;
        buf_has  = 0;
        exp_next = flush ? flush_pc : branch_pc;
      end
      if (data_ok) begin
        in_flight = 0;
        mem_busy  = 0;
        if (stale) n_drop++;
        else begin
          exp_next = cur_addr + 32'd4;
          if (!stall) begin
            exp_fa = 1; exp_inst = mem_word(cur_addr); exp_pc = cur_addr;
          end else begin
            buf_has = 1; buf_addr = cur_addr;
          end
        end
      end else if (buf_has && !stall) begin
        buf_has = 0;
        exp_fa = 1; exp_inst = mem_word(buf_addr); exp_pc = buf_addr;
      end
      if (exp_fa) n_fetch++;
      if (req && addr_ok) begin
        mem_busy = 1; mem_addr = addr;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rnd_final_fa", {31'd0, fa}, {31'd0, exp_fa});
    chk("rnd_enough_fetches", {31'd0, n_fetch > 100}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_perf_fetched", perf_fetched, n_fetch);
    chk("rnd_perf_discarded", perf_discarded, n_drop);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
